// File: rtl/seq_multi.sv
// seq_multi: NCH-channel square-wave / finite-burst pulse sequencer on the shared register bus.
// Optional feature macro: SEQ_TRIGGER_EN (armed external trigger). SEQ_CLOCKRATE sets the clockrate register.
`ifndef SEQ_CLOCKRATE
`define SEQ_CLOCKRATE 32'd100_000_000
`endif

module seq_multi #(
    parameter int         NCH     = 4,
    parameter int         CNT_W   = 32,
    parameter logic [7:0] REGBASE = 8'h20
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [15:0]    reg_addr,
    inout  wire  [31:0]    reg_data,
    input  logic           reg_wr,
    input  logic           trigger,
    output logic [NCH-1:0] outputs
);
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    localparam logic [15:0] GBASE = 16'(REGBASE);

    logic [31:0] wdata;
    logic        ctrl_wr;
    logic        operate_reg, soft_reset_reg;
    logic        arm, trig_latch, run;
    logic [NCH-1:0] done;
    logic [NCH-1:0] chan_hit;
    logic [31:0]    chan_rdata [NCH];
    logic [31:0]    rdata;
    logic           rhit;

    assign wdata   = reg_data;
    assign ctrl_wr = reg_wr && (reg_addr == GBASE);
    assign run     = operate_reg | trig_latch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operate_reg    <= 1'b0;
            soft_reset_reg <= 1'b0;
        end else if (ctrl_wr) begin
            operate_reg    <= wdata[0];
            soft_reset_reg <= wdata[1];
        end
    end

`ifdef SEQ_TRIGGER_EN
    logic arm_reg, trig_latch_reg, sync1_reg, sync2_reg, prev_reg, edge_reg;

    // Two-flop synchroniser, registered rising-edge pulse, then the arm-gated latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_reg        <= 1'b0;
            trig_latch_reg <= 1'b0;
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            prev_reg       <= 1'b0;
            edge_reg       <= 1'b0;
        end else begin
            sync1_reg <= trigger;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            edge_reg  <= sync2_reg & ~prev_reg;
            if (ctrl_wr)
                arm_reg <= wdata[2];
            if (soft_reset_reg || !arm_reg)
                trig_latch_reg <= 1'b0;
            else if (edge_reg)
                trig_latch_reg <= 1'b1;
        end
    end

    assign arm        = arm_reg;
    assign trig_latch = trig_latch_reg;
`else
    logic unused_trigger;
    assign unused_trigger = trigger;
    assign arm            = 1'b0;
    assign trig_latch     = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [15:0] CBASE = 16'(REGBASE) + 16'(8 * (gi + 1));

            logic             enable_reg, init_reg, burst_reg, out_reg;
            logic [CNT_W-1:0] init_count_reg, low_reg, high_reg, counter_reg;
            logic [31:0]      burst_cycles_reg, cycles_reg, cycles_inc;
            logic [15:0]      rel;
            logic [31:0]      rd;
            state_t           state_reg;

            assign rel          = reg_addr - CBASE;
            assign chan_hit[gi] = (rel < 16'd6);
            assign cycles_inc   = cycles_reg + 32'd1;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    enable_reg       <= 1'b0;
                    init_reg         <= 1'b0;
                    burst_reg        <= 1'b0;
                    init_count_reg   <= '0;
                    low_reg          <= '0;
                    high_reg         <= '0;
                    burst_cycles_reg <= '0;
                end else if (reg_wr && chan_hit[gi]) begin
                    case (rel[2:0])
                        3'd0: begin
                            enable_reg <= wdata[0];
                            init_reg   <= wdata[1];
                            burst_reg  <= wdata[2];
                        end
                        3'd1:    init_count_reg   <= wdata[CNT_W-1:0];
                        3'd2:    low_reg          <= wdata[CNT_W-1:0];
                        3'd3:    high_reg         <= wdata[CNT_W-1:0];
                        3'd4:    burst_cycles_reg <= wdata;
                        default: ;
                    endcase
                end
            end

            // Dwell registers are sampled only at reload, so bus writes never disturb the live counter.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg   <= HOLD;
                    out_reg     <= 1'b0;
                    counter_reg <= '0;
                    cycles_reg  <= '0;
                end else if (soft_reset_reg) begin
                    state_reg   <= HOLD;
                    out_reg     <= init_reg;
                    counter_reg <= init_count_reg;
                    cycles_reg  <= '0;
                end else if (run && enable_reg && state_reg != DONE) begin
                    if (burst_reg && cycles_reg >= burst_cycles_reg) begin
                        state_reg <= DONE;
                        out_reg   <= 1'b0;
                    end else begin
                        state_reg <= RUN;
                        if (counter_reg == '0) begin
                            out_reg     <= ~out_reg;
                            counter_reg <= out_reg ? low_reg : high_reg;
                            if (out_reg) begin
                                cycles_reg <= cycles_inc;
                                if (burst_reg && cycles_inc >= burst_cycles_reg)
                                    state_reg <= DONE;
                            end
                        end else begin
                            counter_reg <= counter_reg - 1'b1;
                        end
                    end
                end
            end

            always_comb begin
                rd = '0;
                case (rel[2:0])
                    3'd0:    rd = {29'd0, burst_reg, init_reg, enable_reg};
                    3'd1:    rd = 32'(init_count_reg);
                    3'd2:    rd = 32'(low_reg);
                    3'd3:    rd = 32'(high_reg);
                    3'd4:    rd = burst_cycles_reg;
                    3'd5:    rd = cycles_reg;
                    default: rd = '0;
                endcase
            end

            assign chan_rdata[gi] = rd;
            assign done[gi]       = (state_reg == DONE);
            assign outputs[gi]    = out_reg;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        rhit  = 1'b0;
        if (reg_addr == GBASE) begin
            rhit  = 1'b1;
            rdata = {29'd0, arm, soft_reset_reg, operate_reg};
        end else if (reg_addr == GBASE + 16'd1) begin
            rhit  = 1'b1;
            rdata = `SEQ_CLOCKRATE;
        end else if (reg_addr == GBASE + 16'd2) begin
            rhit            = 1'b1;
            rdata[NCH-1:0]  = done;
            rdata[16]       = run;
        end
        for (int c = 0; c < NCH; c++) begin
            if (chan_hit[c]) begin
                rhit  = 1'b1;
                rdata = chan_rdata[c];
            end
        end
    end

    assign reg_data = (rhit && !reg_wr) ? rdata : 32'bz;

endmodule

// File: tb/tb_seq_multi.sv
// Scoreboard bench for seq_multi: default instance plus a CNT_W=8 single-channel instance.
`ifndef SEQ_CLOCKRATE
`define SEQ_CLOCKRATE 32'd100_000_000
`endif

module tb_seq_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    wire  [31:0] bus0, bus1;
    logic [3:0]  outs0;
    logic [0:0]  outs1;

    assign bus0 = wr0 ? wd0 : 32'bz;
    assign bus1 = wr1 ? wd1 : 32'bz;

    always #5 clk = ~clk;

    seq_multi u_dut (
        .clk(clk), .reset_n(rst_n), .reg_addr(addr0), .reg_data(bus0),
        .reg_wr(wr0), .trigger(trigger), .outputs(outs0)
    );

    seq_multi #(.NCH(1), .CNT_W(8), .REGBASE(8'h20)) u_dut8 (
        .clk(clk), .reset_n(rst_n), .reg_addr(addr1), .reg_data(bus1),
        .reg_wr(wr1), .trigger(1'b0), .outputs(outs1)
    );

    typedef struct {
        int          bus;
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    passed = 0;
    int    total  = 0;
    logic  obs    = 1'b0;

    int free_exp[14]  = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    int burst_exp[10] = '{2, 0, 2, 0, 2, 0, 0, 0, 0, 0};

    // Monitor: pops the oldest expectation whenever an observation point is presented.
    always @(posedge obs) begin
        item_t       it;
        logic [31:0] act;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got observation, required a queued expectation");
        end else begin
            it = sb.pop_front();
            if (it.is_read)
                act = (it.bus == 0) ? bus0 : bus1;
            else
                act = (it.bus == 0) ? 32'(outs0) : 32'(outs1);
            if (act === it.exp) begin
                passed++;
                $display("check %s ok value=%h", it.name, act);
            end else begin
                $display("FAIL %s: got %h required %h", it.name, act, it.exp);
            end
        end
    end

    task automatic push(input int b, input bit r, input logic [31:0] e, input string n);
        item_t it;
        it.bus = b; it.is_read = r; it.exp = e; it.name = n;
        sb.push_back(it);
        obs = 1'b1;
        #1 obs = 1'b0;
    endtask

    task automatic wr(input int b, input logic [15:0] a, input logic [31:0] d);
        if (b == 0) begin addr0 = a; wd0 = d; wr0 = 1'b1; end
        else        begin addr1 = a; wd1 = d; wr1 = 1'b1; end
        @(negedge clk);
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic rd(input int b, input logic [15:0] a, input logic [31:0] e, input string n);
        if (b == 0) addr0 = a; else addr1 = a;
        #1;
        push(b, 1'b1, e, n);
        @(negedge clk);
    endtask

    task automatic chk_out(input int b, input logic [31:0] e, input string n);
        push(b, 1'b0, e, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk_out(0, 32'h0, "reset_outputs");
        rd(0, 16'h20, 32'h0, "reset_control");
        rd(0, 16'h22, 32'h0, "reset_status");
        rd(0, 16'h21, `SEQ_CLOCKRATE, "clockrate");

        // Free-run ch0: init 0, initial_count 2, low 1, high 3
        wr(0, 16'h28, 32'h1);
        wr(0, 16'h29, 32'd2);
        wr(0, 16'h2A, 32'd1);
        wr(0, 16'h2B, 32'd3);
        rd(0, 16'h2B, 32'd3, "ch0_high_readback");
        wr(0, 16'h20, 32'h2);
        wr(0, 16'h20, 32'h1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk_out(0, 32'(free_exp[k]), $sformatf("freerun_k%0d", k + 1));
        end

        // Pause two cycles into a high phase; remaining length must survive
        repeat (2) @(negedge clk);
        wr(0, 16'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_out(0, 32'h1, $sformatf("pause_hold_%0d", k));
        end
        wr(0, 16'h20, 32'h1);
        chk_out(0, 32'h1, "pause_hold_last");
        @(negedge clk);
        chk_out(0, 32'h1, "resume_remaining");
        @(negedge clk);
        chk_out(0, 32'h0, "resume_toggle_low");

        // Burst ch1 (3 pulses, high=low=0) and ch2 (burst_cycles=0, init high)
        wr(0, 16'h28, 32'h0);
        wr(0, 16'h30, 32'h5);
        wr(0, 16'h34, 32'd3);
        wr(0, 16'h38, 32'h7);
        wr(0, 16'h20, 32'h2);
        wr(0, 16'h20, 32'h1);
        chk_out(0, 32'h4, "burst_after_softreset");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_out(0, 32'(burst_exp[k]), $sformatf("burst_k%0d", k + 1));
        end
        rd(0, 16'h22, 32'h0001_0006, "burst_status");
        rd(0, 16'h35, 32'd3, "ch1_cycles_done");
        rd(0, 16'h3D, 32'd0, "ch2_cycles_done");

        // Asynchronous reset mid-run
        wr(0, 16'h28, 32'h1);
        repeat (3) @(negedge clk);
        chk_out(0, 32'h1, "pre_reset_high");
        #1 rst_n = 1'b0;
        #1;
        chk_out(0, 32'h0, "async_reset_out");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 16'h20, 32'h0, "post_reset_control");
        rd(0, 16'h22, 32'h0, "post_reset_status");
        rd(0, 16'h28, 32'h0, "post_reset_ch0_cfg");
        rd(0, 16'h29, 32'h0, "post_reset_ch0_init");
        rd(0, 16'h2B, 32'h0, "post_reset_ch0_high");
        rd(0, 16'h34, 32'h0, "post_reset_ch1_burst");
        rd(0, 16'h35, 32'h0, "post_reset_ch1_done");

        // Arm / trigger
        wr(0, 16'h20, 32'h4);
`ifdef SEQ_TRIGGER_EN
        rd(0, 16'h20, 32'h4, "control_arm");
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        rd(0, 16'h22, 32'h0, "trig_before_latency");
        rd(0, 16'h22, 32'h0001_0000, "trig_run_set");
        trigger = 1'b0;
        wr(0, 16'h20, 32'h0);
        repeat (4) @(negedge clk);
        trigger = 1'b1;
        repeat (6) @(negedge clk);
        rd(0, 16'h22, 32'h0, "trig_unarmed_no_run");
        trigger = 1'b0;
`else
        rd(0, 16'h20, 32'h0, "control_arm_reads0");
        trigger = 1'b1;
        repeat (6) @(negedge clk);
        rd(0, 16'h22, 32'h0, "trigger_ignored");
        trigger = 1'b0;
        wr(0, 16'h20, 32'h0);
`endif

        // CNT_W = 8 instance: truncation and a 256-cycle high phase
        wr(1, 16'h2B, 32'h0000_01FF);
        rd(1, 16'h2B, 32'h0000_00FF, "cnt8_high_readback");
        wr(1, 16'h28, 32'h3);
        wr(1, 16'h20, 32'h2);
        wr(1, 16'h20, 32'h1);
        for (int k = 1; k <= 259; k++) begin
            @(negedge clk);
            case (k)
                1:   chk_out(1, 32'h0, "cnt8_k1_low");
                2:   chk_out(1, 32'h1, "cnt8_k2_rise");
                128: chk_out(1, 32'h1, "cnt8_k128_high");
                257: chk_out(1, 32'h1, "cnt8_k257_last_high");
                258: chk_out(1, 32'h0, "cnt8_k258_fall");
                259: chk_out(1, 32'h1, "cnt8_k259_rise");
                default: ;
            endcase
        end

        #5;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_multi.md
# seq_multi

Parametrised multi-channel pulse sequencer: the next generation of the four-channel sequencer. It generates NCH independent square-wave or finite-burst outputs from per-channel initial, low and high dwell counts. All counters, registers and the register-bus port run on one clock. It sits on the shared register bus and drives the sequencer output pins.

## Interface
- NCH, 4: number of channels, 1–16.
- CNT_W, 32: dwell counter width, 1–32; register bits above CNT_W are ignored on write and read as 0.
- REGBASE, 8'h20: global register base; channel c base = REGBASE + 8*(c+1).
- clk  in  1  sole clock; register bus and counters.
- reset_n  in  1  asynchronous, active-low reset.
- reg_addr  in  16  register address.
- reg_data  inout  32  register data; driven only during a read of an owned address, else high-Z.
- reg_wr  in  1  write strobe, sampled on clk.
- trigger  in  1  external start, asynchronous to clk; used only with SEQ_TRIGGER_EN.
- outputs  out  NCH  channel outputs, registered.

## Operation
- Global registers:
  - REGBASE+0 control: bit0 operate, bit1 soft reset (level), bit2 arm.
  - REGBASE+1 clockrate, read-only = `SEQ_CLOCKRATE.
  - REGBASE+2 status, read-only: bits[NCH-1:0] done[c], bit16 run.
- Channel registers (offset from channel base):
  - +0 config: bit0 enable, bit1 initial state, bit2 burst mode.
  - +1 initial_count.
  - +2 low_count.
  - +3 high_count.
  - +4 burst_cycles (32-bit).
  - +5 cycles_done, read-only (32-bit).
- run = operate | trig_latch. trig_latch is always 0 without the macro.
- Per-channel states: HOLD, RUN, DONE.
- Soft reset = 1 (priority over everything except reset_n):
  - out <= initial state; counter <= initial_count; cycles_done <= 0; done <= 0; state <= HOLD.
- HOLD: moves to RUN on the first cycle with run && enable.
- RUN, each cycle with run && enable:
  - counter == 0: out toggles; counter <= (out ? low_count : high_count).
  - otherwise: counter decrements by 1.
  - A high phase therefore lasts high_count+1 cycles; a low phase lasts low_count+1 cycles.
- run = 0 or enable = 0: counter and out freeze. State is retained; no reload.
- Burst mode:
  - cycles_done increments on each high→low toggle.
  - When cycles_done reaches burst_cycles: the channel enters DONE, out is held low, done[c] = 1.
  - burst_cycles = 0 in burst mode: the channel goes HOLD→DONE on its first run cycle; out is forced low and no toggle occurs.
- Free-run mode (bit2 = 0): cycles_done increments and wraps at 2^32; the channel never enters DONE.
- Writes to dwell registers while in RUN take effect at the next reload only; the in-flight counter is not modified.
- Leaving DONE: soft reset only.

## Timing
- reset_n low, asynchronous: outputs = 0; every register, counter, cycles_done, done and trig_latch = 0; reg_data high-Z.
- Write: captured on the clk edge with reg_wr = 1 and a matching address; visible to channel logic on the following edge.
- Read: reg_data driven combinationally while reg_wr = 0 and the address is owned.
- First edge with run = 1: counter decrements (or toggles if it is 0). outputs change on the clk edge after the counter reaches 0.
- Simultaneous soft reset and reload edge: soft reset wins.
- Simultaneous final high→low toggle and DONE entry occur on the same edge.

## Configuration
- SEQ_TRIGGER_EN defined:
  - trigger passes through a 2-flop synchroniser and a rising-edge detector.
  - An edge seen while arm = 1 sets trig_latch. Soft reset or arm = 0 clears it.
  - Latency: trigger high before edge E gives run = 1 after edge E+3.
- SEQ_TRIGGER_EN not defined:
  - trigger is ignored; control bit2 reads as 0; trig_latch is constant 0; no synchroniser flops are present.

## Test plan
- Free-run, ch0: initial state 0, initial_count = 2, low = 1, high = 3; soft reset pulse, then operate.
  - Required: out0 rises after 3 run cycles, then repeats high 4 cycles / low 2 cycles.
- Burst, ch1: burst_cycles = 3, high = 0, low = 0.
  - Required: exactly 3 one-cycle high pulses, then out1 stays low, status bit1 = 1, cycles_done = 3.
- Pause: drop operate mid high phase for 5 cycles.
  - Required: out and counter frozen for those 5 cycles; the phase resumes with its remaining length intact.
- Async reset: assert reset_n low during RUN.
  - Required: outputs = 0 immediately, without waiting for a clk edge; all registers read 0 after release.
- CNT_W = 8: write high_count = 32'h0000_01FF.
  - Required: reads back 32'hFF; high phase = 256 cycles.
- With SEQ_TRIGGER_EN: arm = 1, operate = 0, pulse trigger.
  - Required: status bit16 = 1 three cycles later. Repeat with arm = 0: run stays 0.
